// File: rtl/saes_pkg.sv
// Shared S-AES definitions: S-boxes, GF(2^4) multiply, round constants,
// state-matrix helpers and the decrypt FSM state type.
package saes_pkg;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        KEYX,
        RK2,
        RND1,
        RND2
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h9;
            4'h1: r = 4'h4;
            4'h2: r = 4'hA;
            4'h3: r = 4'hB;
            4'h4: r = 4'hD;
            4'h5: r = 4'h1;
            4'h6: r = 4'h8;
            4'h7: r = 4'h5;
            4'h8: r = 4'h6;
            4'h9: r = 4'h2;
            4'hA: r = 4'h0;
            4'hB: r = 4'h3;
            4'hC: r = 4'hC;
            4'hD: r = 4'hE;
            4'hE: r = 4'hF;
            default: r = 4'h7;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hA;
            4'h1: r = 4'h5;
            4'h2: r = 4'h9;
            4'h3: r = 4'hB;
            4'h4: r = 4'h1;
            4'h5: r = 4'h7;
            4'h6: r = 4'h8;
            4'h7: r = 4'hF;
            4'h8: r = 4'h6;
            4'h9: r = 4'h0;
            4'hA: r = 4'h2;
            4'hB: r = 4'h3;
            4'hC: r = 4'hC;
            4'hD: r = 4'h4;
            4'hE: r = 4'hD;
            default: r = 4'hE;
        endcase
        return r;
    endfunction

    // Shift-and-add multiply reduced by x^4+x+1 after every shift.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] m;
        p = '0;
        m = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i])
                p = p ^ m;
            m = {m[2:0], 1'b0} ^ (m[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [7:0] rot_nib(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    function automatic logic [7:0] sub_nib8(input logic [7:0] b);
        return {sbox(b[7:4]), sbox(b[3:0])};
    endfunction

    function automatic logic [15:0] inv_shift_row(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] inv_nib_sub(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_mix_columns(input logic [15:0] s);
        logic [3:0] a0, b0, a1, b1;
        a0 = s[15:12];
        b0 = s[11:8];
        a1 = s[7:4];
        b1 = s[3:0];
        return {gf4_mul(4'h9, a0) ^ gf4_mul(4'h2, b0),
                gf4_mul(4'h2, a0) ^ gf4_mul(4'h9, b0),
                gf4_mul(4'h9, a1) ^ gf4_mul(4'h2, b1),
                gf4_mul(4'h2, a1) ^ gf4_mul(4'h9, b1)};
    endfunction

endpackage

// File: rtl/saes_key_expand.sv
// Combinational S-AES key schedule: 16-bit cipher key -> round keys K1, K2.
module saes_key_expand
    import saes_pkg::*;
(
    input  logic [15:0] key,
    output logic [15:0] k1,
    output logic [15:0] k2
);

    logic [7:0] w0, w1, w2, w3, w4, w5;

    assign w0 = key[15:8];
    assign w1 = key[7:0];
    assign w2 = w0 ^ RCON1 ^ sub_nib8(rot_nib(w1));
    assign w3 = w2 ^ w1;
    assign w4 = w2 ^ RCON2 ^ sub_nib8(rot_nib(w3));
    assign w5 = w4 ^ w3;

    assign k1 = {w2, w3};
    assign k2 = {w4, w5};

endmodule

// File: rtl/saes_decrypt_seq.sv
// Iterative S-AES decryption engine with start/busy/done handshake.
// Optional expanded-key cache enabled by defining SAES_KEY_CACHE_EN.
module saes_decrypt_seq
    import saes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key,
    input  logic [15:0] inputText,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] outputText
);

    state_t      state, state_nx;
    logic [15:0] k0_q, k1_q, k2_q;
    logic [15:0] st_q;
    logic [15:0] out_q;
    logic        done_q;
    logic [15:0] k1_x, k2_x;
    logic [15:0] rnd1_val, rnd2_val;
    logic        hit;

    saes_key_expand u_key_expand (
        .key (k0_q),
        .k1  (k1_x),
        .k2  (k2_x)
    );

`ifdef SAES_KEY_CACHE_EN
    // k1_q/k2_q are only rewritten in KEYX, so they already hold the
    // expansion of cache_key whenever cache_valid is set.
    logic [15:0] cache_key;
    logic        cache_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key   <= '0;
            cache_valid <= 1'b0;
        end else if (state == KEYX) begin
            cache_key   <= k0_q;
            cache_valid <= 1'b1;
        end
    end

    assign hit = cache_valid && (key == cache_key);
`else
    assign hit = 1'b0;
`endif

    assign rnd1_val = inv_mix_columns(inv_nib_sub(inv_shift_row(st_q)) ^ k1_q);
    assign rnd2_val = inv_nib_sub(inv_shift_row(st_q)) ^ k0_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = hit ? RK2 : KEYX;
            KEYX:    state_nx = RK2;
            RK2:     state_nx = RND1;
            RND1:    state_nx = RND2;
            RND2:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k0_q   <= '0;
            k1_q   <= '0;
            k2_q   <= '0;
            st_q   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k0_q <= key;
                        st_q <= inputText;
                    end
                end
                KEYX: begin
                    k1_q <= k1_x;
                    k2_q <= k2_x;
                end
                RK2:  st_q <= st_q ^ k2_q;
                RND1: st_q <= rnd1_val;
                RND2: begin
                    out_q  <= rnd2_val;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign outputText = out_q;

endmodule

// File: tb/tb_saes_decrypt_seq.sv
// Self-checking bench for saes_decrypt_seq: cycle-level behavioural model
// plus directed vectors and randomized traffic.
module tb_saes_decrypt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key;
    logic [15:0] inputText;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] outputText;

    always #5 clk = ~clk;

    saes_decrypt_seq dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .inputText  (inputText),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .outputText (outputText)
    );

`ifdef SAES_KEY_CACHE_EN
    localparam int LAT_HIT = 4;
`else
    localparam int LAT_HIT = 5;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit started  = 0;

    // model state
    int          remaining = 0;
    logic        exp_busy  = 1'b0;
    logic        exp_done  = 1'b0;
    logic [15:0] exp_out   = '0;
    logic [15:0] pending   = '0;
    logic [15:0] c_key     = '0;
    bit          c_valid   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int bt = 6; bt >= 4; bt--)
            if (((p >> bt) & 1) != 0) p = p ^ ('h13 << (bt - 4));
        return p;
    endfunction

    function automatic logic [15:0] model_decrypt(input logic [15:0] c, input logic [15:0] k);
        int sb[16]   = '{'h9, 'h4, 'hA, 'hB, 'hD, 'h1, 'h8, 'h5, 'h6, 'h2, 'h0, 'h3, 'hC, 'hE, 'hF, 'h7};
        int isb[16]  = '{'hA, 'h5, 'h9, 'hB, 'h1, 'h7, 'h8, 'hF, 'h6, 'h0, 'h2, 'h3, 'hC, 'h4, 'hD, 'hE};
        int rcon[2]  = '{'h80, 'h30};
        int w[6];
        int rk[3];
        int n[4];
        int t, a, b;
        logic [15:0] res;
        w[0] = int'(k) >> 8;
        w[1] = int'(k) & 'hFF;
        for (int r = 0; r < 2; r++) begin
            t = ((w[2*r+1] & 'hF) << 4) | (w[2*r+1] >> 4);
            t = (sb[t >> 4] << 4) | sb[t & 'hF];
            w[2*r+2] = w[2*r] ^ rcon[r] ^ t;
            w[2*r+3] = w[2*r+2] ^ w[2*r+1];
        end
        for (int i = 0; i < 3; i++) rk[i] = (w[2*i] << 8) | w[2*i+1];
        for (int i = 0; i < 4; i++) n[i] = ((int'(c) >> (12 - 4*i)) & 'hF) ^ ((rk[2] >> (12 - 4*i)) & 'hF);
        for (int r = 1; r <= 2; r++) begin
            t = n[1]; n[1] = n[3]; n[3] = t;
            for (int i = 0; i < 4; i++) n[i] = isb[n[i]] ^ ((rk[2-r] >> (12 - 4*i)) & 'hF);
            if (r == 1) begin
                for (int col = 0; col < 2; col++) begin
                    a = n[2*col];
                    b = n[2*col+1];
                    n[2*col]   = gmul(9, a) ^ gmul(2, b);
                    n[2*col+1] = gmul(2, a) ^ gmul(9, b);
                end
            end
        end
        res = 16'((n[0] << 12) | (n[1] << 8) | (n[2] << 4) | n[3]);
        return res;
    endfunction

    // Cycle model: a transaction counts down its latency, then presents its result.
    always @(posedge clk) begin
        bit hit;
        cyc++;
        started = 1;
        if (rst) begin
            remaining = 0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            exp_out   = '0;
            c_valid   = 0;
        end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                    exp_out  = pending;
                end
            end else if (start) begin
`ifdef SAES_KEY_CACHE_EN
                hit = c_valid && (key == c_key);
`else
                hit = 0;
`endif
                remaining = (hit ? 4 : 5) - 1;
                exp_busy  = 1'b1;
                pending   = model_decrypt(inputText, key);
                if (!hit) begin
                    c_key   = key;
                    c_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("outputText", {16'd0, outputText}, {16'd0, exp_out});
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic issue(input logic [15:0] k, input logic [15:0] c, output int t0);
        key       = k;
        inputText = c;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int lat, input logic [15:0] expv, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen)
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({nm, "_latency"}, cyc - t0, lat);
            chk({nm, "_data"}, {16'd0, outputText}, {16'd0, expv});
        end
    endtask

    initial begin
        int t0, t1, dc;
        logic [15:0] pool [3];
        rst = 1'b1; start = 1'b0; key = '0; inputText = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_out", {16'd0, outputText}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        chk("model_v1", {16'd0, model_decrypt(16'h0738, 16'hA73B)}, 32'h6F6B);
        chk("model_v2", {16'd0, model_decrypt(16'h24EC, 16'h4AF5)}, 32'hD728);

        // vector 1, then vector 2 back-to-back in the done cycle
        issue(16'hA73B, 16'h0738, t0);
        chk("v1_busy_n1", {31'd0, busy}, 32'd1);
        wait_done(t0, 5, 16'h6F6B, "v1");
        issue(16'h4AF5, 16'h24EC, t1);
        wait_done(t1, 5, 16'hD728, "v2_b2b");

        // repeated key: second one may hit the cache
        issue(16'hA73B, 16'h0738, t0);
        wait_done(t0, 5, 16'h6F6B, "v1_keychange");
        issue(16'hA73B, 16'h0738, t0);
        wait_done(t0, LAT_HIT, 16'h6F6B, "v1_repeat");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        issue(16'hA73B, 16'h0738, t0);
        wait_done(t0, 5, 16'h6F6B, "v1_after_rst");

        // start held high across a transaction
        @(negedge clk);
        key = 16'h4AF5; inputText = 16'h24EC; start = 1'b1; t0 = cyc;
        wait_done(t0, 5, 16'hD728, "held_first");
        t1 = cyc;
        @(negedge clk); start = 1'b0;
        wait_done(t1, LAT_HIT, 16'hD728, "held_second");

        // reset during RND1 aborts without a done pulse
        @(negedge clk);
        issue(16'h1234, 16'hBEEF, t0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dc  = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out", {16'd0, outputText}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, dc);
        issue(16'h4AF5, 16'h24EC, t0);
        wait_done(t0, 5, 16'hD728, "after_abort");

        // randomized traffic from a small key pool to exercise cache hits
        pool[0] = 16'hA73B; pool[1] = 16'h4AF5; pool[2] = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            key       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 2)];
            inputText = 16'($urandom);
            rst       = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
